// File: rtl/fetch_if.sv
// Fetch-stage bundle: instruction-memory request/response, decode handoff and branch redirect.
// The fetch stage takes the master view; the surrounding core/memory take the slave view.
interface fetch_if #(
  parameter int WIDTH = 32
);
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             imem_req_valid;
  logic             imem_req_ready;
  logic [WIDTH-1:0] imem_req_addr;
  logic             imem_rsp_valid;
  logic [31:0]      imem_rsp_data;
  logic             if_valid;
  logic             if_ready;
  logic [WIDTH-1:0] if_pc;
  logic [31:0]      if_instr;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_stage.sv
// LX32 instruction-fetch stage: owns the PC, keeps one imem request in flight and hands
// {pc, instr} to decode; a redirect from execute squashes the stale fetch and restarts.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
  parameter int               PC_STEP  = 4
) (
  input  logic    clk,
  input  logic    rst,
  fetch_if.master bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(3));

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             if_valid_q, if_valid_d;
  logic [WIDTH-1:0] if_pc_q, if_pc_d;
  logic [31:0]      if_instr_q, if_instr_d;
  logic [WIDTH-1:0] redirect_tgt;

  assign redirect_tgt = bus.redirect_pc & ALIGN_MASK;

  // Next-state, PC and decode-buffer update; a redirect always overrides the sequential PC.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (bus.redirect_valid) pc_d = redirect_tgt;
        else                    pc_d = pc_q;
      end
      S_REQ: begin
        if (bus.redirect_valid) begin
          pc_d = redirect_tgt;
          // An accepted request is already stale: its response must be swallowed.
          if (bus.imem_req_ready) state_d = S_DROP;
          else                    state_d = S_REQ;
        end else if (bus.imem_req_ready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid && bus.redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_REQ;
        end else if (bus.imem_rsp_valid) begin
          if_instr_d = bus.imem_rsp_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_q + STEP;
          state_d    = S_HOLD;
        end else if (bus.redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (bus.redirect_valid) pc_d = redirect_tgt;
        else                    pc_d = pc_q;
        if (bus.imem_rsp_valid) state_d = S_REQ;
        else                    state_d = S_DROP;
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d       = redirect_tgt;
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end else if (bus.if_ready) begin
          if_valid_d = 1'b0;
          state_d    = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d    = S_IDLE;
        if_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_pc_q    <= {WIDTH{1'b0}};
      if_instr_q <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.if_valid       = if_valid_q;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instr       = if_instr_q;

  fetch_stage_chk u_chk (
    .clk          (clk),
    .rst          (rst),
    .rsp_valid    (bus.imem_rsp_valid),
    .rsp_expected ((state_q == S_WAIT) || (state_q == S_DROP)),
    .if_valid     (if_valid_q),
    .req_valid    (state_q == S_REQ)
  );
endmodule

// Protocol monitor: responses only while one is owed, and no request while decode holds an instruction.
module fetch_stage_chk (
  input logic clk,
  input logic rst,
  input logic rsp_valid,
  input logic rsp_expected,
  input logic if_valid,
  input logic req_valid
);
  a_rsp_in_window: assert property (@(posedge clk) disable iff (rst) rsp_valid |-> rsp_expected);
  a_no_req_held:   assert property (@(posedge clk) disable iff (rst) if_valid |-> !req_valid);
endmodule
